// File: rtl/mmu_result_deskew_if.sv
// Row-result bus of the MMU output collector: the skewed column streams going
// in and the realigned row (raw accumulators plus clamped pixels) coming out.
interface mmu_result_deskew_if #(
    parameter int ACC_W = 24
);
    logic                 in_valid;
    logic [ACC_W-1:0]     col0_in;
    logic [ACC_W-1:0]     col1_in;
    logic [ACC_W-1:0]     col2_in;
    logic [ACC_W-1:0]     col3_in;
    logic                 res_valid;
    logic                 res_ready;
    logic [4*ACC_W-1:0]   res_acc;
    logic [31:0]          res_pix;

    // Array side plus row consumer.
    modport master (
        output in_valid, col0_in, col1_in, col2_in, col3_in, res_ready,
        input  res_valid, res_acc, res_pix
    );

    // Deskew block.
    modport slave (
        input  in_valid, col0_in, col1_in, col2_in, col3_in, res_ready,
        output res_valid, res_acc, res_pix
    );
endinterface

// File: rtl/mmu_result_deskew.sv
// Realigns the time-skewed bottom-row outputs of the 4x4 systolic array into
// complete rows, buffers them in a small FIFO and presents each row as raw
// accumulators plus a shifted, 8-bit-clamped pixel word.
module mmu_result_deskew #(
    parameter int ACC_W      = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int SHIFT      = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    mmu_result_deskew_if.slave bus,
    output logic [15:0]        row_cnt,
    output logic               overflow
);
    localparam int NUM_COLS = 4;
    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int CW       = $clog2(FIFO_DEPTH + 1);

    typedef logic [NUM_COLS-1:0][ACC_W-1:0] row_t;

    // vld_pipe[k] marks a row token whose column k is on the inputs this cycle;
    // stage 0 is in_valid itself, so the four stages span t..t+3.
    logic [3:1]            vld_pipe;
    logic [2:0][ACC_W-1:0] c0_d;
    logic [1:0][ACC_W-1:0] c1_d;
    logic [ACC_W-1:0]      c2_d;
    row_t                  row_asm;
    row_t                  head;
    row_t                  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         occ;
    logic                  row_done;
    logic                  full;
    logic                  do_pop;
    logic                  do_push;

    // Advance row tokens; flush drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     vld_pipe <= '0;
        else if (flush) vld_pipe <= '0;
        else            vld_pipe <= {vld_pipe[2:1], bus.in_valid};
    end

    // Capture each column only in its own slot so idle-cycle junk never enters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0_d <= '0;
            c1_d <= '0;
            c2_d <= '0;
        end else begin
            if (bus.in_valid) c0_d[0] <= bus.col0_in;
            if (vld_pipe[1]) begin
                c0_d[1] <= c0_d[0];
                c1_d[0] <= bus.col1_in;
            end
            if (vld_pipe[2]) begin
                c0_d[2] <= c0_d[1];
                c1_d[1] <= c1_d[0];
                c2_d    <= bus.col2_in;
            end
        end
    end

    // Column 3 arrives last and joins the delayed columns directly.
    always_comb begin
        row_asm    = '0;
        row_asm[0] = c0_d[2];
        row_asm[1] = c1_d[1];
        row_asm[2] = c2_d;
        row_asm[3] = bus.col3_in;
    end

    assign row_done = vld_pipe[3];
    assign full     = (occ == CW'(FIFO_DEPTH));
    assign do_pop   = !flush && bus.res_valid && bus.res_ready;
    // A full FIFO still takes the row when the head leaves in the same edge.
    assign do_push  = !flush && row_done && (!full || do_pop);

    // Row storage; contents need no reset since the head is gated by occupancy.
    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr] <= row_asm;
    end

    // Pointers, occupancy, accepted-row count and sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            row_cnt  <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            row_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                row_cnt <= row_cnt + 16'd1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      occ <= occ + 1'b1;
            else if (!do_push && do_pop) occ <= occ - 1'b1;
            if (row_done && !do_push) overflow <= 1'b1;
        end
    end

    assign bus.res_valid = (occ != '0);
    assign head          = bus.res_valid ? fifo_mem[rd_ptr] : '0;
    assign bus.res_acc   = head;

    // Unsigned brightness scaling and saturation to one byte per column.
    for (genvar j = 0; j < NUM_COLS; j++) begin : g_clamp
        logic [ACC_W-1:0] shifted;
        assign shifted = head[j] >> SHIFT;
        assign bus.res_pix[8*j +: 8] = (|shifted[ACC_W-1:8]) ? 8'hFF : shifted[7:0];
    end
endmodule
